// File: rtl/add_sub_serial_p.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first, over WIDTH-bit operands,
// with valid/ready handshakes, carry/no-borrow and signed overflow flags.
module add_sub_serial_p #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = $clog2(NDIG) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_out;
    logic               r_cout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [DIGIT:0]     w_sum;
    logic               w_last;
    logic               w_msb_cin;

    assign w_sum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_carry);
    assign w_last = (r_state == S_ADD) && (r_count == CW'(NDIG - 1));
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];

    // State register plus handshake/busy flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt == S_ADD);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_ADD;
            S_ADD:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture at accept, one digit per ADD cycle, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= mode ? ~b : b;
                        r_carry <= mode;
                        r_count <= '0;
                        r_out   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_out   <= (r_out >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_sum[DIGIT];
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_cout <= w_sum[DIGIT];
                        r_ovf  <= w_msb_cin ^ w_sum[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out       = r_out;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
